// File: rtl/sm_add_rom_arbiter.sv
// sm_add_rom_arbiter
//   Round-robin arbiter and sequencer for two requesters that share one
//   sign-magnitude-add lookup ROM. The ROM address is {a,b}. The ROM returns
//   the sum after a registered read of ROM_LAT cycles. Each accepted request
//   is tracked by a {valid, id} tag pipeline. The ROM word is captured into
//   the issuing requester's result register, and that requester gets a
//   one-cycle valid pulse. Throughput is one lookup per cycle.
//
//   Configuration macro: SMROM_OUTREG_EN
//     undefined : ROM_LAT = 1, grant-to-vld latency 2 cycles
//     defined   : ROM has an extra output register, ROM_LAT = 2,
//                 grant-to-vld latency 3 cycles
//
//   Ports
//     clk            system clock, rising edge
//     reset_n        asynchronous active-low reset
//     req0/a0/b0     requester 0 request and operands (held until gnt0)
//     gnt0           combinational accept strobe for requester 0
//     vld0/res0      result pulse and last result for requester 0
//     req1..res1     the same set for requester 1
//     rom_addr       combinational ROM address, 0 when idle
//     rom_data       ROM read data
//     busy           high while a grant is issued or any lookup is in flight
//
//   Handshake: a request is accepted in the cycle where gnt is high. The
//   requester keeps req and its operands stable until it sees gnt. A request
//   that is withdrawn before it is granted leaves no trace.
module sm_add_rom_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0,
  input  logic [DATA_W-1:0]   a0,
  input  logic [DATA_W-1:0]   b0,
  output logic                gnt0,
  output logic                vld0,
  output logic [DATA_W-1:0]   res0,
  input  logic                req1,
  input  logic [DATA_W-1:0]   a1,
  input  logic [DATA_W-1:0]   b1,
  output logic                gnt1,
  output logic                vld1,
  output logic [DATA_W-1:0]   res1,
  output logic [2*DATA_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                busy
);

`ifdef SMROM_OUTREG_EN
  localparam int ROM_LAT = 2;
`else
  localparam int ROM_LAT = 1;
`endif

  // last_q holds the id of the most recent grant. It resets to 1, so
  // requester 0 wins the first contested cycle.
  logic               last_q, last_d;
  logic [ROM_LAT:0]   tag_v_q, tag_v_d;
  logic [ROM_LAT:0]   tag_id_q, tag_id_d;
  logic [DATA_W-1:0]  res0_q, res0_d;
  logic [DATA_W-1:0]  res1_q, res1_d;

  logic gnt0_c, gnt1_c, grant_any;

  // Grants are forced low while reset is asserted, so all outputs read 0
  // during reset even if requests are pending.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        if (last_q) gnt0_c = 1'b1;
        else        gnt1_c = 1'b1;
      end else if (req0) begin
        gnt0_c = 1'b1;
      end else if (req1) begin
        gnt1_c = 1'b1;
      end
    end
  end

  assign grant_any = gnt0_c | gnt1_c;

  always_comb begin
    rom_addr = '0;
    if (gnt0_c)      rom_addr = {a0, b0};
    else if (gnt1_c) rom_addr = {a1, b1};
  end

  // Stage k holds the tag during cycle T+1+k. The ROM word for a grant in
  // cycle T is on rom_data during cycle T+ROM_LAT, when the tag sits in stage
  // ROM_LAT-1. The capture happens then, and the tag reaches the last stage
  // in the same cycle the result becomes visible. That stage drives vld.
  always_comb begin
    last_d   = last_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    tag_v_d  = {tag_v_q[ROM_LAT-1:0], grant_any};
    tag_id_d = {tag_id_q[ROM_LAT-1:0], gnt1_c};
    if (grant_any) last_d = gnt1_c;
    if (tag_v_q[ROM_LAT-1] && !tag_id_q[ROM_LAT-1]) res0_d = rom_data;
    if (tag_v_q[ROM_LAT-1] &&  tag_id_q[ROM_LAT-1]) res1_d = rom_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= 1'b1;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      last_q   <= last_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
    end
  end

  assign gnt0 = gnt0_c;
  assign gnt1 = gnt1_c;
  assign vld0 = tag_v_q[ROM_LAT] & ~tag_id_q[ROM_LAT];
  assign vld1 = tag_v_q[ROM_LAT] &  tag_id_q[ROM_LAT];
  assign res0 = res0_q;
  assign res1 = res1_q;
  assign busy = (|tag_v_q) | grant_any;

endmodule

// File: tb/tb_sm_add_rom_arbiter.sv
// Directed bench for sm_add_rom_arbiter. It contains a behavioural
// sign-magnitude-add ROM with the same read latency as the DUT build.
module tb_sm_add_rom_arbiter;

`ifdef SMROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, vld0, vld1, busy;
  logic [7:0]  res0, res1, rom_data;
  logic [15:0] rom_addr;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  sm_add_rom_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .vld0(vld0), .res0(res0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .vld1(vld1), .res1(res1),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  // ROM model: sign-magnitude sum, with +0 for equal magnitudes of opposite sign.
  function automatic logic [7:0] sm_add(input logic [15:0] ad);
    logic       sa, sb;
    logic [6:0] ma, mb;
    sa = ad[15]; ma = ad[14:8];
    sb = ad[7];  mb = ad[6:0];
    if (sa == sb)      return {sa, 7'(ma + mb)};
    else if (ma == mb) return 8'h00;
    else if (ma > mb)  return {sa, 7'(ma - mb)};
    else               return {sb, 7'(mb - ma)};
  endfunction

  logic [7:0] rom_r1 = 8'h00;
  logic [7:0] rom_r2 = 8'h00;
  always @(posedge clk) begin
    rom_r1 <= sm_add(rom_addr);
    rom_r2 <= rom_r1;
  end
`ifdef SMROM_OUTREG_EN
  assign rom_data = rom_r2;
`else
  assign rom_data = rom_r1;
`endif

  // scoreboard compare
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive just after the rising edge, check on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive0(input logic r, input logic [7:0] a, input logic [7:0] b);
    req0 = r; a0 = a; b0 = b;
  endtask

  task automatic drive1(input logic r, input logic [7:0] a, input logic [7:0] b);
    req1 = r; a1 = a; b1 = b;
  endtask

  // Operand tables for the alternating run, with hand-computed sums.
  logic [15:0] ops0 [3] = '{16'h0102, 16'h1085, 16'h8A82};
  logic [7:0]  sum0 [3] = '{8'h03, 8'h0B, 8'h8C};
  logic [15:0] ops1 [3] = '{16'h8503, 16'h2020, 16'h0787};
  logic [7:0]  sum1 [3] = '{8'h82, 8'h40, 8'h00};

  initial begin
    reset_n = 1'b0;
    drive0(1'b0, 8'h00, 8'h00);
    drive1(1'b0, 8'h00, 8'h00);

    // reset state
    settle();
    chk("rst_gnt0", {15'd0, gnt0}, 16'd0);
    chk("rst_gnt1", {15'd0, gnt1}, 16'd0);
    chk("rst_vld0", {15'd0, vld0}, 16'd0);
    chk("rst_vld1", {15'd0, vld1}, 16'd0);
    chk("rst_res0", {8'd0, res0}, 16'd0);
    chk("rst_res1", {8'd0, res1}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    next_cycle();
    reset_n = 1'b1;

    // single request on port 0: 5 + 3
    next_cycle();
    drive0(1'b1, 8'h05, 8'h03);
    settle();
    chk("s1_gnt0", {15'd0, gnt0}, 16'd1);
    chk("s1_gnt1", {15'd0, gnt1}, 16'd0);
    chk("s1_addr", rom_addr, 16'h0503);
    chk("s1_busy", {15'd0, busy}, 16'd1);
    next_cycle();
    drive0(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < LAT; i++) begin
      settle();
      chk("s1_vld0_early", {15'd0, vld0}, 16'd0);
      next_cycle();
    end
    settle();
    chk("s1_vld0", {15'd0, vld0}, 16'd1);
    chk("s1_vld1", {15'd0, vld1}, 16'd0);
    chk("s1_res0", {8'd0, res0}, 16'h0008);
    next_cycle();
    settle();
    chk("s1_vld0_after", {15'd0, vld0}, 16'd0);
    chk("s1_res0_hold", {8'd0, res0}, 16'h0008);

    // single request on port 1: +3 + -5 = -2
    next_cycle();
    drive1(1'b1, 8'h03, 8'h85);
    settle();
    chk("s2_gnt1", {15'd0, gnt1}, 16'd1);
    chk("s2_gnt0", {15'd0, gnt0}, 16'd0);
    chk("s2_addr", rom_addr, 16'h0385);
    next_cycle();
    drive1(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < LAT; i++) next_cycle();
    settle();
    chk("s2_vld1", {15'd0, vld1}, 16'd1);
    chk("s2_vld0", {15'd0, vld0}, 16'd0);
    chk("s2_res1", {8'd0, res1}, 16'h0082);
    chk("s2_res0_hold", {8'd0, res0}, 16'h0008);

    // both requesters held for six grants: order 0,1,0,1,0,1
    next_cycle();
    for (int k = 0; k <= 6 + LAT; k++) begin
      if (k == 0) begin
        drive0(1'b1, ops0[0][15:8], ops0[0][7:0]);
        drive1(1'b1, ops1[0][15:8], ops1[0][7:0]);
      end else if (k == 6) begin
        drive0(1'b0, 8'h00, 8'h00);
        drive1(1'b0, 8'h00, 8'h00);
      end else if ((k - 1) % 2 == 0 && (k - 1) / 2 + 1 < 3) begin
        drive0(1'b1, ops0[(k-1)/2+1][15:8], ops0[(k-1)/2+1][7:0]);
      end else if ((k - 1) % 2 == 1 && (k - 1) / 2 + 1 < 3) begin
        drive1(1'b1, ops1[(k-1)/2+1][15:8], ops1[(k-1)/2+1][7:0]);
      end
      settle();
      if (k < 6) begin
        chk($sformatf("alt_gnt0_%0d", k), {15'd0, gnt0}, (k % 2 == 0) ? 16'd1 : 16'd0);
        chk($sformatf("alt_gnt1_%0d", k), {15'd0, gnt1}, (k % 2 == 1) ? 16'd1 : 16'd0);
        chk($sformatf("alt_addr_%0d", k), rom_addr, (k % 2 == 0) ? ops0[k/2] : ops1[k/2]);
        exp_q.push_back((k % 2 == 0) ? sum0[k/2] : sum1[k/2]);
      end
      if (k >= LAT + 1) begin
        int j;
        logic [7:0] e;
        j = k - LAT - 1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (j % 2 == 0) begin
          chk($sformatf("alt_vld0_%0d", j), {15'd0, vld0}, 16'd1);
          chk($sformatf("alt_vld1n_%0d", j), {15'd0, vld1}, 16'd0);
          chk($sformatf("alt_res0_%0d", j), {8'd0, res0}, {8'd0, e});
        end else begin
          chk($sformatf("alt_vld1_%0d", j), {15'd0, vld1}, 16'd1);
          chk($sformatf("alt_vld0n_%0d", j), {15'd0, vld0}, 16'd0);
          chk($sformatf("alt_res1_%0d", j), {8'd0, res1}, {8'd0, e});
        end
      end else begin
        chk($sformatf("alt_novld_%0d", k), {14'd0, vld1, vld0}, 16'd0);
      end
      next_cycle();
    end
    settle();
    chk("alt_drained", {14'd0, vld1, vld0}, 16'd0);
    chk("alt_queue_empty", 16'(exp_q.size()), 16'd0);

    // grant, then reset while the lookup is in flight
    next_cycle();
    drive0(1'b1, 8'h05, 8'h03);
    settle();
    chk("mr_gnt0", {15'd0, gnt0}, 16'd1);
    next_cycle();
    drive0(1'b0, 8'h00, 8'h00);
    drive1(1'b1, 8'h11, 8'h22);
    reset_n = 1'b0;
    settle();
    chk("mr_gnt", {14'd0, gnt1, gnt0}, 16'd0);
    chk("mr_vld", {14'd0, vld1, vld0}, 16'd0);
    chk("mr_res0", {8'd0, res0}, 16'd0);
    chk("mr_res1", {8'd0, res1}, 16'd0);
    chk("mr_busy", {15'd0, busy}, 16'd0);
    chk("mr_addr", rom_addr, 16'h0000);
    next_cycle();
    reset_n = 1'b1;
    drive1(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < LAT + 2; i++) begin
      settle();
      chk($sformatf("mr_novld_%0d", i), {14'd0, vld1, vld0}, 16'd0);
      next_cycle();
    end
    // pointer is back to preferring requester 0
    drive0(1'b1, 8'h01, 8'h01);
    drive1(1'b1, 8'h02, 8'h02);
    settle();
    chk("pr_gnt0", {15'd0, gnt0}, 16'd1);
    chk("pr_gnt1", {15'd0, gnt1}, 16'd0);
    next_cycle();
    drive0(1'b0, 8'h00, 8'h00);
    settle();
    chk("pr_gnt1_next", {15'd0, gnt1}, 16'd1);
    next_cycle();
    drive1(1'b0, 8'h00, 8'h00);
    settle();
    if (LAT == 1) chk("pr_res0", {7'd0, vld0, res0}, 16'h0102);
    for (int i = 0; i < LAT + 2; i++) next_cycle();

    // idle
    settle();
    chk("idle_addr", rom_addr, 16'h0000);
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_gnt", {14'd0, gnt1, gnt0}, 16'd0);
    chk("idle_res1", {8'd0, res1}, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_add_rom_arbiter.md
Name: sm_add_rom_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 65536x8 sign-magnitude-add lookup ROM.
- The ROM has a 1-cycle registered read; address is {a,b}, data is the 8-bit sign-magnitude sum.
- The arbiter muxes each requester's operand pair onto the ROM address and tracks in-flight reads with a tag pipeline.
- It returns each result, with a valid pulse, to the requester that issued it. Sustains one lookup per cycle.

Parameters:
- DATA_W, 8, operand/result width; rom_addr width = 2*DATA_W.
- ROM_LAT, 1, ROM read latency in cycles; forced to 2 when SMROM_OUTREG_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 lookup request; held with a0/b0 stable until gnt0 is seen high.
- a0  in  DATA_W  requester 0 operand A (sign-magnitude).
- b0  in  DATA_W  requester 0 operand B (sign-magnitude).
- gnt0  out  1  combinational; high in the cycle requester 0's request is accepted.
- vld0  out  1  one-cycle pulse; res0 holds a new result.
- res0  out  DATA_W  last result returned to requester 0.
- req1, a1, b1, gnt1, vld1, res1: same as the port-0 set, for requester 1.
- rom_addr  out  2*DATA_W  combinational ROM address.
- rom_data  in  DATA_W  ROM read data.
- busy  out  1  high while any lookup is in flight.

Behaviour:
- Reset values: gnt0/gnt1 = 0, vld0/vld1 = 0, res0/res1 = 0, busy = 0.
  - Priority pointer resets to requester 0 preferred.
  - Tag pipeline is cleared.
- Grant (combinational, cycle T):
  - Only one request high: grant it.
  - Both high: grant the requester not granted most recently.
  - Pointer updates at the edge ending T, only when a grant occurs.
  - At most one gnt high per cycle.
- rom_addr:
  - {a0,b0} when gnt0; {a1,b1} when gnt1.
  - 16'h0000 when idle. Drive 0 deterministically, never X.
- Tag pipeline:
  - ROM_LAT+1 stages of {valid, id}.
  - Stage 0 is loaded at the edge ending T with {grant_any, granted_id}.
- Result capture (registered):
  - At the edge ending T+ROM_LAT, res<id> <= rom_data.
  - vld<id> is high during cycle T+ROM_LAT+1 only.
  - Total latency, grant to vld: ROM_LAT+1 cycles (2 by default).
  - res of the non-target port is unchanged.
- Back-to-back:
  - Grants in consecutive cycles are legal.
  - Results return in grant order, one per cycle, no bubbles, no drops.
- Alternating: with both requesters held high continuously, grants alternate 0,1,0,1...
- busy = OR of all tag valid bits, plus any current grant.
- Reset mid-operation (reset_n low at any time):
  - Immediately clears tags, vld, res, gnt, pointer.
  - In-flight lookups are discarded; no vld pulses follow reset release.
- Requester dropping req before grant: no effect, no grant issued.

Optional Feature:
- Macro: SMROM_OUTREG_EN.
- Defined:
  - The arbiter instantiates/assumes the ROM variant with an extra output register, so ROM_LAT = 2.
  - Tag pipeline is one stage deeper.
  - Grant-to-vld latency = 3 cycles; throughput unchanged.
- Undefined: ROM_LAT = 1, latency 2 cycles.

Test Plan:
- Reset, then req0=1, a0=8'h05, b0=8'h03.
  - gnt0=1 in that cycle, rom_addr=16'h0503.
  - Two cycles later vld0=1, res0=8'h08; vld1 stays 0.
- req1 only, a1=8'h03, b1=8'h85 (+3 + -5).
  - gnt1=1, then vld1 pulse with res1=8'h82; res0 unchanged.
- Both requesters held high 6 cycles, distinct operands.
  - Grant order 0,1,0,1,0,1.
  - Six vld pulses on consecutive cycles starting 2 cycles after the first grant, each with the correct per-port result.
- Grant in cycle T, then reset_n=0 at T+1 for 1 cycle.
  - All outputs 0 during reset; no vld pulse afterwards.
  - First post-reset simultaneous request is granted to requester 0.
- Idle cycles with no req: rom_addr=16'h0000, busy=0, gnt0=gnt1=0.
- With SMROM_OUTREG_EN defined, repeat the first scenario.
  - vld0 asserts 3 cycles after gnt0, res0=8'h08.
  - Back-to-back throughput is still one result per cycle.
